// File: rtl/lcd_frame_scanner.sv
// Buffers the 10x10 game table from the status FSM and repaints it on a KS0108 left controller.
// Define LCD_FRAME_BORDER_EN to also draw a solid right-edge border column at x=60 on every page.
module lcd_frame_scanner #(
    parameter int T_SETUP = 8,
    parameter int T_EN    = 20,
    parameter int T_HOLD  = 16
) (
    input  logic       clk_40M,
    input  logic       rst,
    input  logic       lcd_status,
    input  logic [3:0] lcd_row,
    input  logic [9:0] lcd_data,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_cs1,
    output logic       frame_done
);
    localparam int TXN_LEN = T_SETUP + T_EN + T_HOLD;
    localparam int CW      = $clog2(TXN_LEN + 1);
`ifdef LCD_FRAME_BORDER_EN
    localparam logic [5:0] X_LAST = 6'd60;
`else
    localparam logic [5:0] X_LAST = 6'd59;
`endif

    typedef enum logic [2:0] {
        S_INIT_ON,
        S_INIT_LINE,
        S_IDLE,
        S_SET_PAGE,
        S_SET_COL,
        S_DATA
    } state_t;

    state_t        state, state_n;
    logic [9:0]    wbuf [10];
    logic [9:0]    dbuf [10];
    logic          pending, status_q, commit;
    logic [CW-1:0] cnt;
    logic          txn_last, en_window;
    logic [2:0]    page;
    logic [5:0]    x;
    logic [3:0]    row_idx;
    logic [2:0]    sub;
    logic [9:0]    row_bits;
    logic [7:0]    data_byte, bus_db;
    logic          bus_rs, start_frame, frame_end, frame_q;

    assign lcd_rw    = 1'b0;
    assign commit    = status_q & ~lcd_status;
    assign txn_last  = (cnt == CW'(TXN_LEN - 1));
    assign en_window = (cnt >= CW'(T_SETUP)) && (cnt < CW'(T_SETUP + T_EN));

    // A commit landing on the same edge IDLE consumes pending keeps the flag set.
    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) wbuf[i] <= '0;
            status_q <= 1'b0;
            pending  <= 1'b1;
        end else begin
            status_q <= lcd_status;
            if (lcd_status && (lcd_row <= 4'd9)) wbuf[lcd_row] <= lcd_data;
            pending <= (pending && !start_frame) || commit;
        end
    end

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) dbuf[i] <= '0;
        end else if (start_frame) begin
            for (int i = 0; i < 10; i++) dbuf[i] <= wbuf[i];
        end
    end

    always_comb begin
        row_bits  = (row_idx <= 4'd9) ? dbuf[row_idx] : '0;
        data_byte = {{4{row_bits[{page, 1'b1}]}}, {4{row_bits[{page, 1'b0}]}}};
`ifdef LCD_FRAME_BORDER_EN
        if (x == X_LAST) data_byte = 8'hFF;
`endif
    end

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        bus_rs      = 1'b0;
        bus_db      = 8'h00;
        case (state)
            S_INIT_ON: begin
                bus_db = 8'h3F;
                if (txn_last) state_n = S_INIT_LINE;
            end
            S_INIT_LINE: begin
                bus_db = 8'hC0;
                if (txn_last) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (pending) begin
                    start_frame = 1'b1;
                    state_n     = S_SET_PAGE;
                end
            end
            S_SET_PAGE: begin
                bus_db = {5'b10111, page};
                if (txn_last) state_n = S_SET_COL;
            end
            S_SET_COL: begin
                bus_db = 8'h40;
                if (txn_last) state_n = S_DATA;
            end
            S_DATA: begin
                bus_rs = 1'b1;
                bus_db = data_byte;
                if (txn_last && (x == X_LAST)) begin
                    if (page == 3'd4) begin
                        frame_end = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        state_n = S_SET_PAGE;
                    end
                end
            end
            default: state_n = S_INIT_ON;
        endcase
    end

    // x walks the auto-incrementing column; row_idx/sub track x/6 and x%6 without a divider.
    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            state   <= S_INIT_ON;
            cnt     <= '0;
            page    <= '0;
            x       <= '0;
            row_idx <= '0;
            sub     <= '0;
        end else begin
            state <= state_n;
            if ((state == S_IDLE) || txn_last) cnt <= '0;
            else                               cnt <= cnt + 1'b1;
            if (start_frame) page <= '0;
            if ((state == S_DATA) && txn_last) begin
                if (x == X_LAST) begin
                    x       <= '0;
                    row_idx <= '0;
                    sub     <= '0;
                    if (page != 3'd4) page <= page + 1'b1;
                end else begin
                    x <= x + 1'b1;
                    if (sub == 3'd5) begin
                        sub     <= '0;
                        row_idx <= row_idx + 1'b1;
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
            end
        end
    end

    // Pins are a registered copy of the FSM view, so each transaction is glitch-free and
    // frame_done trails the final hold cycle by one clock.
    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            lcd_db     <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_cs1    <= 1'b0;
            frame_q    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            lcd_db     <= bus_db;
            lcd_rs     <= bus_rs;
            lcd_en     <= (state != S_IDLE) && en_window;
            lcd_cs1    <= (state != S_IDLE);
            frame_q    <= frame_end;
            frame_done <= frame_q;
        end
    end
endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Directed bench for lcd_frame_scanner: captures every LCD strobe and compares whole frames
// against a table model; shortened bus timing keeps the run small.
module tb_lcd_frame_scanner;
    localparam int T_SETUP = 3;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int TXN     = T_SETUP + T_EN + T_HOLD;
`ifdef LCD_FRAME_BORDER_EN
    localparam int NX = 61;
`else
    localparam int NX = 60;
`endif
    localparam int FRAME_TXNS = 5 * (2 + NX);
    localparam int FRAME_LEN  = FRAME_TXNS * TXN;

    logic       clk_40M = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_status = 1'b0;
    logic [3:0] lcd_row = '0;
    logic [9:0] lcd_data = '0;
    logic [7:0] lcd_db;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_cs1, frame_done;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         page0_cyc = -1;
    int         en_w = 0;
    logic       en_prev = 1'b0;
    logic [8:0] txq[$];
    int         lenq[$];
    logic [9:0] wmod [10];
    logic [9:0] tbl  [10];
    logic [9:0] snap [10];

    lcd_frame_scanner #(.T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD)) dut (
        .clk_40M(clk_40M), .rst(rst), .lcd_status(lcd_status), .lcd_row(lcd_row),
        .lcd_data(lcd_data), .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_cs1(lcd_cs1), .frame_done(frame_done)
    );

    always #5 clk_40M = ~clk_40M;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expByte(input int p, input int x);
        logic [9:0] r;
        if (x >= 60) return 8'hFF;
        r = tbl[x / 6];
        return {{4{r[2*p+1]}}, {4{r[2*p]}}};
    endfunction

    // Strobe monitor: logs {rs,db} on every enable rise and measures pulse width and frame span.
    always @(negedge clk_40M) begin
        cyc++;
        if (rst) begin
            en_prev   = 1'b0;
            en_w      = 0;
            page0_cyc = -1;
        end else begin
            if (lcd_en && !en_prev) begin
                checkOutput("cs1_at_strobe", int'(lcd_cs1), 1);
                txq.push_back({lcd_rs, lcd_db});
                if ({lcd_rs, lcd_db} == 9'h0B8) page0_cyc = cyc;
            end
            if (lcd_en) en_w++;
            else if (en_prev) begin
                checkOutput("en_width", en_w, T_EN);
                en_w = 0;
            end
            if (frame_done) lenq.push_back(cyc - page0_cyc);
            en_prev = lcd_en;
        end
    end

    task automatic applyStimulus(input logic [3:0] row, input logic [9:0] data);
        lcd_status = 1'b1;
        lcd_row    = row;
        lcd_data   = data;
        if (row <= 4'd9) wmod[row] = data;
        @(negedge clk_40M);
    endtask

    task automatic commitTable();
        lcd_status = 1'b0;
        @(negedge clk_40M);
    endtask

    task automatic waitFrame(input string tag, input int budget);
        int n = 0;
        while ((lenq.size() == 0) && (n < budget)) begin
            @(negedge clk_40M);
            n++;
        end
        checkOutput({tag, "_frame_seen"}, int'(lenq.size() > 0), 1);
        if (lenq.size() > 0) checkOutput({tag, "_frame_len"}, lenq.pop_front(), FRAME_LEN - T_SETUP);
    endtask

    task automatic checkFrame(input string tag, input bit with_init);
        int exp_n = FRAME_TXNS + (with_init ? 2 : 0);
        checkOutput({tag, "_txn_count"}, txq.size(), exp_n);
        if (txq.size() != exp_n) begin
            txq.delete();
            return;
        end
        if (with_init) begin
            checkOutput({tag, "_init_on"}, txq.pop_front(), 9'h03F);
            checkOutput({tag, "_init_line"}, txq.pop_front(), 9'h0C0);
        end
        for (int p = 0; p < 5; p++) begin
            checkOutput($sformatf("%s_set_page%0d", tag, p), txq.pop_front(), 9'h0B8 + p);
            checkOutput($sformatf("%s_set_col%0d", tag, p), txq.pop_front(), 9'h040);
            for (int x = 0; x < NX; x++)
                checkOutput($sformatf("%s_p%0d_x%0d", tag, p, x), txq.pop_front(), {1'b1, expByte(p, x)});
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 10; i++) begin
            wmod[i] = '0;
            tbl[i]  = '0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_40M);
        checkOutput("rst_db", lcd_db, 8'h00);
        checkOutput("rst_rs", int'(lcd_rs), 0);
        checkOutput("rst_rw", int'(lcd_rw), 0);
        checkOutput("rst_en", int'(lcd_en), 0);
        checkOutput("rst_cs1", int'(lcd_cs1), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;

        waitFrame("boot", 6000);
        tbl = wmod;
        checkFrame("boot", 1'b1);

        applyStimulus(4'd0, 10'b0000000011);
        commitTable();
        waitFrame("row0", 6000);
        tbl = wmod;
        checkFrame("row0", 1'b0);

        applyStimulus(4'd0, 10'b0000000000);
        applyStimulus(4'd9, 10'b1000000000);
        commitTable();
        waitFrame("row9", 6000);
        tbl = wmod;
        checkFrame("row9", 1'b0);

        applyStimulus(4'd12, 10'h3FF);
        commitTable();
        waitFrame("row12", 6000);
        tbl = wmod;
        checkFrame("row12", 1'b0);

        applyStimulus(4'd5, 10'h0AA);
        commitTable();
        snap = wmod;
        n = 0;
        while (!lcd_cs1 && (n < 100)) begin
            @(negedge clk_40M);
            n++;
        end
        checkOutput("multi_frame_start", int'(lcd_cs1), 1);
        repeat (100) @(negedge clk_40M);
        applyStimulus(4'd3, 10'h155);
        commitTable();
        repeat (50) @(negedge clk_40M);
        applyStimulus(4'd3, 10'h0F0);
        commitTable();
        repeat (50) @(negedge clk_40M);
        applyStimulus(4'd3, 10'h3FF);
        commitTable();
        waitFrame("multi_a", 6000);
        tbl = snap;
        checkFrame("multi_a", 1'b0);
        waitFrame("multi_b", 6000);
        tbl = wmod;
        checkFrame("multi_b", 1'b0);
        repeat (500) @(negedge clk_40M);
        checkOutput("no_extra_frame", lenq.size(), 0);
        checkOutput("no_extra_txn", txq.size(), 0);

        applyStimulus(4'd7, 10'h0C3);
        commitTable();
        n = 0;
        while (!(lcd_rs && lcd_en) && (n < 5000)) begin
            @(negedge clk_40M);
            n++;
        end
        checkOutput("data_strobe_seen", int'(lcd_rs && lcd_en), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_en", int'(lcd_en), 0);
        checkOutput("midrst_cs1", int'(lcd_cs1), 0);
        checkOutput("midrst_db", lcd_db, 8'h00);
        for (int i = 0; i < 10; i++) wmod[i] = '0;
        repeat (3) @(negedge clk_40M);
        txq.delete();
        lenq.delete();
        rst = 1'b0;
        waitFrame("post_rst", 6000);
        tbl = wmod;
        checkFrame("post_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
